// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and baud helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } uart_parity_t;

  // Raw 2-bit mode field to parity enum; the unused code 11 falls back to NONE.
  function automatic uart_parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction

  // Clocks per bit for a given clock and baud rate, rounded to nearest.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int unsigned DEFAULT_CLK_HZ       = 50_000_000;
  localparam int unsigned DEFAULT_BAUD         = 115_200;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = clks_per_bit(DEFAULT_CLK_HZ, DEFAULT_BAUD);

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..N-1 and flags the last cycle of each bit.
// Held at zero while restart is high so the first bit after release is full length.
module uart_bit_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst,
  input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
  input  logic                 i_Restart,
  output logic                 o_Bit_End
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] last_cnt;

  // A divisor of 0 behaves as 1, i.e. every cycle is a bit boundary.
  assign last_cnt  = (i_Clks_Per_Bit == '0) ? '0 : i_Clks_Per_Bit - DIV_WIDTH'(1);
  assign o_Bit_End = !i_Restart && (cnt_q == last_cnt);

  // Next count: wrap at the bit boundary or when restarted.
  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (i_Restart || o_Bit_End) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: N clocks per bit, DATA_BITS data bits
// LSB first, optional even/odd parity, one or two stop bits, ready/valid input.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst,
  input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Stop_Bits,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DIV_WIDTH-1:0] n_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 stop2_q;
  logic                 stop_idx_q;
  logic                 ser_q;
  logic                 act_q;
  logic                 done_q;
  logic                 bit_end;
  logic                 timer_restart;

  // Timer is parked while idle so START always gets a full N cycles.
  assign timer_restart = (state_q == IDLE);

  uart_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_bit_timer (
    .i_Clock       (i_Clock),
    .i_Rst         (i_Rst),
    .i_Clks_Per_Bit(n_q),
    .i_Restart     (timer_restart),
    .o_Bit_End     (bit_end)
  );

  assign o_TX_Ready  = (state_q == IDLE);
  assign o_TX_Active = act_q;
  assign o_TX_Serial = ser_q;
  assign o_TX_Done   = done_q;

  // Frame FSM: the serial level is registered on the edge that enters each bit.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      n_q        <= DIV_WIDTH'(1);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      ser_q      <= 1'b1;
      act_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ser_q <= 1'b1;
          act_q <= 1'b0;
          if (i_TX_DV) begin
            // Snapshot word and configuration; inputs are free until the next accept.
            shift_q    <= i_TX_Byte;
            n_q        <= (i_Clks_Per_Bit == '0) ? DIV_WIDTH'(1) : i_Clks_Per_Bit;
            par_en_q   <= (decode_parity(i_Parity_Mode) != NONE);
            par_bit_q  <= (decode_parity(i_Parity_Mode) == ODD) ? ~^i_TX_Byte : ^i_TX_Byte;
            stop2_q    <= i_Stop_Bits;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            ser_q      <= 1'b0;
            act_q      <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            ser_q   <= shift_q[0];
            idx_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == LAST_IDX) begin
              if (par_en_q) begin
                ser_q   <= par_bit_q;
                state_q <= PARITY;
              end else begin
                ser_q      <= 1'b1;
                stop_idx_q <= 1'b0;
                state_q    <= STOP;
              end
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              shift_q <= shift_q >> 1;
              ser_q   <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            ser_q      <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_idx_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              act_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          ser_q   <= 1'b1;
          act_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter, successor to the fixed 8N1 transmitter. It serialises one `DATA_BITS`-wide word per frame, LSB first, with a runtime-selectable baud divisor, parity (none/even/odd) and stop-bit count (1/2). It adds a ready/valid input handshake and sits between a byte source (CPU register block or FIFO) and the `o_TX_Serial` pad.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `DIV_WIDTH`, default 16: width of the baud divisor input.
- `i_Clock` in 1: system clock.
- `i_Rst` in 1: synchronous, active-high reset.
- `i_Clks_Per_Bit` in `DIV_WIDTH`: clocks per bit, N = f_clk / baud; 0 is treated as 1.
- `i_Parity_Mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `i_Stop_Bits` in 1: 0 gives one stop bit, 1 gives two stop bits.
- `i_TX_DV` in 1: input word valid.
- `i_TX_Byte` in `DATA_BITS`: word to send.
- `o_TX_Ready` out 1: block can accept a word; high exactly when the state is IDLE.
- `o_TX_Active` out 1: frame in progress.
- `o_TX_Serial` out 1: serial line; idles high.
- `o_TX_Done` out 1: one-cycle pulse at end of frame.

## Operation
- States: IDLE → START → DATA → PARITY (skipped when parity is none) → STOP → IDLE.
- Accept:
  - A word is accepted on the rising edge where `i_TX_DV && o_TX_Ready` is true.
  - On that edge the block latches the word, N, parity mode and stop count; these inputs are don't-care until the next accept.
- START: `o_TX_Serial`=0 for N cycles.
- DATA:
  - Bit i is `data[i]` for i = 0 … `DATA_BITS`-1.
  - Each bit is held N cycles.
  - A bit-index counter of width `$clog2(DATA_BITS)`, minimum 1, ends at `DATA_BITS`-1.
- PARITY: for N cycles, send `^data` for even or `~^data` for odd.
- STOP: `o_TX_Serial`=1 for N cycles per stop bit, i.e. N or 2N cycles.
- Frame end:
  - On the last STOP cycle's edge: go to IDLE, pulse `o_TX_Done` for one cycle, deassert `o_TX_Active`.
- Bit-period counter:
  - Width `DIV_WIDTH`; counts 0 … N−1, clears at each bit boundary.
  - No overflow is possible because N ≤ 2^`DIV_WIDTH`−1.
- `i_TX_DV` while not ready is ignored; it is neither queued nor an error.
- Mid-frame changes to the config inputs have no effect on the frame in progress.

## Timing
- Reset values, all registered: state IDLE, `o_TX_Serial`=1, `o_TX_Active`=0, `o_TX_Done`=0, counters 0; `o_TX_Ready`=1.
- Reset mid-frame: on the next edge the line returns high and the frame is abandoned with no `o_TX_Done` pulse.
- Accept edge E: from E onward, `o_TX_Serial`=0, `o_TX_Active`=1 and `o_TX_Ready`=0.
- Frame length: N·(1 + `DATA_BITS` + P + S) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `o_TX_Done` and `o_TX_Ready` rise on the same edge, which closes the frame.
- Back-to-back frames: if `i_TX_DV` is high during the Done cycle, the next word is accepted on that cycle's edge. The minimum inter-frame gap is 1 clock of idle-high.
- N=1: every bit lasts exactly one clock; no state is skipped.

## Structure
- `uart_pkg`, shared with the receiver:
  - state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity enum `uart_parity_t` (NONE, EVEN, ODD);
  - localparam helper for N from clock and baud.
- Sub-module `uart_bit_timer`: loadable divisor counter with inputs N and restart, and a one-cycle `o_Bit_End` output. The receiver reuses it.
- Top module: FSM, shift/index logic, parity generation and output registers.

## Test plan
- `DATA_BITS`=8, N=4, parity none, 1 stop, send 0xA5:
  - line reads 0,1,0,1,0,0,1,0,1,1 with each level held 4 clocks;
  - frame is 40 cycles;
  - `o_TX_Done` pulses once on cycle 40.
- N=4, even parity, 2 stops:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0;
  - frame is 48 cycles;
  - odd mode inverts both parity bits.
- `DATA_BITS`=5, N=1, 0x1F, no parity, 1 stop: line reads 0,1,1,1,1,1,1; frame is 7 cycles.
- Back-to-back: `i_TX_DV` held high with 0x55 then 0xAA:
  - second start bit begins exactly 1 idle clock after the first Done;
  - `i_TX_DV` pulses issued mid-frame are ignored.
- `i_Rst` asserted on cycle 15 of a frame:
  - next cycle shows `o_TX_Serial`=1, `o_TX_Active`=0, `o_TX_Ready`=1;
  - no Done pulse.
- `i_Clks_Per_Bit`=0 behaves identically to 1; changing `i_Clks_Per_Bit` from 4 to 8 mid-frame leaves the current frame's timing unchanged.
